muldiv_ctrl: RTL and testbench

- Multi-cycle multiply/divide sequencer that owns all writes into the HI/LO register pair: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- Sits in the EX stage. Accepts one operation per start pulse, stalls the pipeline while iterating, then emits a one-cycle write (hilo_we, hi_o, lo_o) into the HI/LO register.
- Multiply uses iterative shift-add; divide uses iterative restoring division. Uniform fixed latency for predictable stalls.

---
 rtl/muldiv_if.sv | 26 ++
 rtl/muldiv_ctrl.sv | 151 +++++++++++++++
 tb/tb_muldiv_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// Request/result bundle between the EX stage and the HI/LO multiply-divide sequencer.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi_in;
  logic [WIDTH-1:0] lo_in;
  logic             cancel;
  logic             stall_o;
  logic             hilo_we;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output start, op, a, b, hi_in, lo_in, cancel,
    input  stall_o, hilo_we, hi_o, lo_o
  );

  modport slave (
    input  start, op, a, b, hi_in, lo_in, cancel,
    output stall_o, hilo_we, hi_o, lo_o
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// Iterative shift-add multiplier / restoring divider that owns every HI/LO write.
// Fixed latency: accept, ITER run cycles, then a one-cycle registered write.
module muldiv_ctrl #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input logic     clk,
  input logic     rst,
  muldiv_if.slave bus
);

  localparam int CNT_W = $clog2(ITER);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   orig_a;
  logic               is_div;
  logic               neg_res;
  logic               neg_rem;
  logic               div0;
  logic               hilo_we;
  logic [WIDTH-1:0]   hi_o;
  logic [WIDTH-1:0]   lo_o;

  logic               accept;
  logic               op_signed;
  logic               op_div;
  logic               op_mt;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] result;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_if_wide(input logic [2*WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  assign op_signed = (bus.op == 3'd1) || (bus.op == 3'd3);
  assign op_div    = (bus.op == 3'd3) || (bus.op == 3'd4);
  assign op_mt     = (bus.op == 3'd5) || (bus.op == 3'd6);
  assign accept    = (state == IDLE) && bus.start && !bus.cancel &&
                     (bus.op >= 3'd1) && (bus.op <= 3'd4);
  assign a_mag     = mag(bus.a, op_signed);
  assign b_mag     = mag(bus.b, op_signed);

  assign bus.stall_o = (state == RUN) || accept;
  assign bus.hilo_we = hilo_we;
  assign bus.hi_o    = hi_o;
  assign bus.lo_o    = lo_o;

  // One iteration: acc holds {partial product | multiplier} or {remainder | dividend/quotient}
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    trial    = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
    acc_next = acc;
    if (!is_div) begin
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    end else if (!trial[WIDTH]) begin
      acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_next = {acc[2*WIDTH-2:WIDTH-1], acc[WIDTH-2:0], 1'b0};
    end
  end

  // Sign fix on the magnitude result; divide-by-zero bypasses it entirely
  always_comb begin
    result = neg_if_wide(acc_next, neg_res);
    if (is_div) begin
      if (div0) begin
        result = {orig_a, {WIDTH{1'b1}}};
      end else begin
        result = {neg_if(acc_next[2*WIDTH-1:WIDTH], neg_rem),
                  neg_if(acc_next[WIDTH-1:0], neg_res)};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      opnd    <= '0;
      orig_a  <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
      hilo_we <= 1'b0;
      hi_o    <= '0;
      lo_o    <= '0;
    end else if (bus.cancel) begin
      state   <= IDLE;
      hilo_we <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          hilo_we <= 1'b0;
          if (accept) begin
            state   <= RUN;
            cnt     <= '0;
            is_div  <= op_div;
            orig_a  <= bus.a;
            neg_res <= op_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_rem <= op_signed && bus.a[WIDTH-1];
            div0    <= (bus.b == '0);
            opnd    <= op_div ? b_mag : a_mag;
            acc     <= {{WIDTH{1'b0}}, (op_div ? a_mag : b_mag)};
          end else if (bus.start && op_mt) begin
            hilo_we <= 1'b1;
            hi_o    <= (bus.op == 3'd5) ? bus.a : bus.hi_in;
            lo_o    <= (bus.op == 3'd5) ? bus.lo_in : bus.a;
          end
        end
        RUN: begin
          acc <= acc_next;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(ITER - 1)) begin
            state   <= DONE;
            hilo_we <= 1'b1;
            hi_o    <= result[2*WIDTH-1:WIDTH];
            lo_o    <= result[WIDTH-1:0];
          end
        end
        DONE: begin
          hilo_we <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state   <= IDLE;
          hilo_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed-vector bench for muldiv_ctrl: latency, stall window, results, cancel and reset.
module tb_muldiv_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(32)) bus ();

  muldiv_ctrl #(.WIDTH(32), .ITER(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Starts op in the current cycle (N) and checks stall N..N+32, write at N+33, idle at N+34.
  task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input bit poke);
    int   st;
    logic early_we;
    st = 0;
    early_we = 1'b0;
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    #1;
    if (bus.stall_o) st++;
    tick;
    bus.start = 1'b0;
    bus.a     = 32'hDEAD_BEEF;
    bus.b     = 32'h0BAD_F00D;
    for (int k = 1; k <= 32; k++) begin
      bus.start = poke && (k == 5);
      bus.op    = poke ? 3'd2 : op;
      #1;
      if (bus.stall_o) st++;
      early_we |= bus.hilo_we;
      tick;
    end
    bus.start = 1'b0;
    #1;
    check({tag, "_stall_cycles"}, 64'(st), 64'd33);
    check({tag, "_early_we"}, 64'(early_we), 64'd0);
    check({tag, "_stall_done"}, 64'(bus.stall_o), 64'd0);
    check({tag, "_we"}, 64'(bus.hilo_we), 64'd1);
    check({tag, "_hi"}, 64'(bus.hi_o), 64'(ehi));
    check({tag, "_lo"}, 64'(bus.lo_o), 64'(elo));
    tick;
    check({tag, "_we_off"}, 64'(bus.hilo_we), 64'd0);
  endtask

  task automatic run_mt(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] ehi, input logic [31:0] elo);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    #1;
    check({tag, "_stall"}, 64'(bus.stall_o), 64'd0);
    tick;
    bus.start = 1'b0;
    bus.a     = 32'h0;
    #1;
    check({tag, "_we"}, 64'(bus.hilo_we), 64'd1);
    check({tag, "_hi"}, 64'(bus.hi_o), 64'(ehi));
    check({tag, "_lo"}, 64'(bus.lo_o), 64'(elo));
    check({tag, "_state_idle"}, 64'(bus.stall_o), 64'd0);
    tick;
    check({tag, "_we_off"}, 64'(bus.hilo_we), 64'd0);
  endtask

  initial begin
    logic any_we;
    bus.start  = 1'b0;
    bus.op     = 3'd0;
    bus.a      = '0;
    bus.b      = '0;
    bus.hi_in  = 32'h0000_0011;
    bus.lo_in  = 32'h0000_0055;
    bus.cancel = 1'b0;
    repeat (3) tick;
    rst = 1'b0;
    check("rst_we", 64'(bus.hilo_we), 64'd0);
    check("rst_hi", 64'(bus.hi_o), 64'd0);
    check("rst_lo", 64'(bus.lo_o), 64'd0);
    check("rst_stall", 64'(bus.stall_o), 64'd0);

    run_md("multu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
    run_md("mult_neg3x5", 3'd1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0);
    run_md("mult_min_sq", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 0);
    run_md("mult_7xneg6", 3'd1, 32'd7, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 0);
    run_md("div_neg7_2", 3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    run_md("div_7_neg2", 3'd3, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 0);
    run_md("divu_100_7", 3'd4, 32'd100, 32'd7, 32'd2, 32'd14, 1);
    run_md("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 0);
    run_md("divu_by0", 3'd4, 32'h0000_1234, 32'h0, 32'h0000_1234, 32'hFFFF_FFFF, 0);
    run_md("div_by0_neg", 3'd3, 32'hFFFF_FFFB, 32'h0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 0);

    run_mt("mthi", 3'd5, 32'h0000_00AA, 32'h0000_00AA, 32'h0000_0055);
    run_mt("mtlo", 3'd6, 32'h0000_00CC, 32'h0000_0011, 32'h0000_00CC);

    // NOP op and start-with-cancel must both be ignored
    bus.start = 1'b1;
    bus.op    = 3'd7;
    #1;
    check("nop_stall", 64'(bus.stall_o), 64'd0);
    tick;
    bus.op     = 3'd1;
    bus.cancel = 1'b1;
    #1;
    check("nop_we", 64'(bus.hilo_we), 64'd0);
    check("startcancel_stall", 64'(bus.stall_o), 64'd0);
    tick;
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    #1;
    check("startcancel_idle", 64'(bus.stall_o), 64'd0);
    check("startcancel_we", 64'(bus.hilo_we), 64'd0);

    // Cancel a MULT at N+10, then a DIVU from N+11 completes at N+44
    bus.start = 1'b1;
    bus.op    = 3'd1;
    bus.a     = 32'd9;
    bus.b     = 32'd9;
    any_we    = 1'b0;
    tick;
    bus.start = 1'b0;
    for (int k = 1; k < 10; k++) begin
      any_we |= bus.hilo_we;
      tick;
    end
    bus.cancel = 1'b1;
    #1;
    check("cancel_stall_n10", 64'(bus.stall_o), 64'd1);
    tick;
    bus.cancel = 1'b0;
    #1;
    check("cancel_stall_n11", 64'(bus.stall_o), 64'd0);
    check("cancel_no_we", 64'(any_we | bus.hilo_we), 64'd0);
    run_md("divu_after_cancel", 3'd4, 32'd1000, 32'd10, 32'd0, 32'd100, 0);

    // Reset during a DIV: outputs cleared, no write ever emerges
    bus.start = 1'b1;
    bus.op    = 3'd3;
    bus.a     = 32'd50;
    bus.b     = 32'd5;
    tick;
    bus.start = 1'b0;
    repeat (4) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    check("midrst_we", 64'(bus.hilo_we), 64'd0);
    check("midrst_hi", 64'(bus.hi_o), 64'd0);
    check("midrst_lo", 64'(bus.lo_o), 64'd0);
    check("midrst_stall", 64'(bus.stall_o), 64'd0);
    any_we = 1'b0;
    for (int k = 0; k < 40; k++) begin
      any_we |= bus.hilo_we | bus.stall_o;
      tick;
    end
    check("midrst_quiet", 64'(any_we), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
